// File: rtl/hamming74_pkg.sv
// hamming74_pkg: Hamming(7,4) widths, codeword bit positions, encoder and syndrome helpers shared by tx and decoder
package hamming74_pkg;
  localparam int CW_W = 7;
  localparam int D_W = 4;
  localparam int P1_POS = 0;
  localparam int P2_POS = 1;
  localparam int D0_POS = 2;
  localparam int P4_POS = 3;
  localparam int D1_POS = 4;
  localparam int D2_POS = 5;
  localparam int D3_POS = 6;
  function automatic logic [CW_W-1:0] hamming74_enc(input logic [D_W-1:0] d);
    logic [CW_W-1:0] c;
    c = '0;
    c[D0_POS] = d[0];
    c[D1_POS] = d[1];
    c[D2_POS] = d[2];
    c[D3_POS] = d[3];
    c[P1_POS] = d[0] ^ d[1] ^ d[3];
    c[P2_POS] = d[0] ^ d[2] ^ d[3];
    c[P4_POS] = d[1] ^ d[2] ^ d[3];
    return c;
  endfunction
  function automatic logic [2:0] hamming74_syn(input logic [CW_W-1:0] cw);
    return {cw[3] ^ cw[4] ^ cw[5] ^ cw[6], cw[1] ^ cw[2] ^ cw[5] ^ cw[6], cw[0] ^ cw[2] ^ cw[4] ^ cw[6]};
  endfunction
endpackage

// File: rtl/hamming74_encoder_tx_if.sv
// hamming74_encoder_tx_if: nibble valid/ready in, codeword valid/ready out, plus inj_en/inj_pos error-injection controls
interface hamming74_encoder_tx_if;
  import hamming74_pkg::*;
  logic [D_W-1:0] in_data;
  logic in_valid;
  logic in_ready;
  logic inj_en;
  logic [2:0] inj_pos;
  logic [CW_W-1:0] out_cw;
  logic out_valid;
  logic out_ready;
  modport master(output in_data, in_valid, inj_en, inj_pos, out_ready, input in_ready, out_cw, out_valid);
  modport slave(input in_data, in_valid, inj_en, inj_pos, out_ready, output in_ready, out_cw, out_valid);
endinterface

// File: rtl/hamming74_encoder_tx_sync_fifo.sv
// sync_fifo: DEPTH x W FIFO (clock, rst_n, push/pop/wdata in; rdata, registered full/empty, level out)
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic         clock,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty,
  output logic [AW:0]  level
);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic full_q, empty_q, do_push, do_pop;
  always_comb begin
    do_push = push & ~full_q;
    do_pop = pop & ~empty_q;
    wptr_d = wptr_q + (AW+1)'(do_push);
    rptr_d = rptr_q + (AW+1)'(do_pop);
  end
  always_ff @(posedge clock or negedge rst_n)
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      full_q <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      full_q <= (wptr_d[AW] != rptr_d[AW]) && (wptr_d[AW-1:0] == rptr_d[AW-1:0]);
      empty_q <= wptr_d == rptr_d;
    end
  always_ff @(posedge clock)
    if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata;
  assign rdata = mem_q[rptr_q[AW-1:0]];
  assign full = full_q;
  assign empty = empty_q;
  assign level = wptr_q - rptr_q;
endmodule

// File: rtl/hamming74_encoder_tx.sv
// hamming74_encoder_tx: FIFO-buffered nibbles Hamming(7,4)-encoded into a registered codeword stream with bit-flip injection, cw_count and fifo_lvl
module hamming74_encoder_tx import hamming74_pkg::*; #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                     clock,
  input  logic                     rst_n,
  hamming74_encoder_tx_if.slave    bus,
  output logic [CNT_W-1:0]         cw_count,
  output logic [$clog2(DEPTH):0]   fifo_lvl
);
  logic [D_W-1:0] head;
  logic full, empty, load, hs;
  logic out_valid_q, out_valid_d;
  logic [CW_W-1:0] out_cw_q, out_cw_d, inj_mask;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  sync_fifo #(.DEPTH(DEPTH), .W(D_W)) u_fifo (
    .clock(clock),
    .rst_n(rst_n),
    .push(bus.in_valid),
    .pop(load),
    .wdata(bus.in_data),
    .rdata(head),
    .full(full),
    .empty(empty),
    .level(fifo_lvl)
  );
  always_comb begin
    hs = out_valid_q & bus.out_ready;
    load = ~empty & (~out_valid_q | bus.out_ready);
    inj_mask = bus.inj_en && bus.inj_pos != 3'd0 ? CW_W'(1) << (bus.inj_pos - 3'd1) : '0;
    out_cw_d = load ? hamming74_enc(head) ^ inj_mask : out_cw_q;
    out_valid_d = load | (out_valid_q & ~bus.out_ready);
    cnt_d = cnt_q + CNT_W'(hs);
  end
  always_ff @(posedge clock or negedge rst_n)
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_cw_q <= '0;
      cnt_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_cw_q <= out_cw_d;
      cnt_q <= cnt_d;
    end
  assign bus.in_ready = ~full;
  assign bus.out_valid = out_valid_q;
  assign bus.out_cw = out_cw_q;
  assign cw_count = cnt_q;
endmodule

// File: tb/tb_hamming74_encoder_tx.sv
// tb_hamming74_encoder_tx: self-checking bench with vector table, directed corner sequences and a queue-based reference model
module tb_hamming74_encoder_tx;
  import hamming74_pkg::*;
  localparam int DEPTH = 4;
  localparam int CNT_W = 16;
  localparam int NV = 11;
  logic clock = 1'b0;
  logic rst_n = 1'b0;
  logic [CNT_W-1:0] cw_count;
  logic [$clog2(DEPTH):0] fifo_lvl;
  int checks = 0;
  int failures = 0;
  hamming74_encoder_tx_if bus();
  hamming74_encoder_tx #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clock(clock),
    .rst_n(rst_n),
    .bus(bus),
    .cw_count(cw_count),
    .fifo_lvl(fifo_lvl)
  );
  always #5 clock = ~clock;
  typedef struct {
    logic [3:0] d;
    logic       en;
    logic [2:0] pos;
    logic [6:0] cw;
  } vec_t;
  vec_t vt [NV];
  logic [3:0] mq [$];
  logic mv = 1'b0;
  logic [6:0] mcw = '0;
  logic [CNT_W-1:0] mcnt = '0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  function automatic logic [6:0] ref_enc(input logic [3:0] d);
    logic [7:1] c;
    int dp [4];
    dp = '{3, 5, 6, 7};
    c = '0;
    for (int i = 0; i < 4; i++) c[dp[i]] = d[i];
    for (int k = 0; k < 3; k++)
      for (int p = 1; p < 8; p++)
        if (p[k] && p != (1 << k)) c[1 << k] ^= c[p];
    return c;
  endfunction
  always @(negedge clock) begin
    bit hs, ld, pu;
    if (!rst_n) begin
      mq.delete();
      mv = 1'b0;
      mcw = '0;
      mcnt = '0;
    end else begin
      chk("in_ready", 32'(bus.in_ready), 32'(mq.size() < DEPTH));
      chk("out_valid", 32'(bus.out_valid), 32'(mv));
      if (mv) chk("out_cw", 32'(bus.out_cw), 32'(mcw));
      chk("fifo_lvl", 32'(fifo_lvl), 32'(mq.size()));
      chk("cw_count", 32'(cw_count), 32'(mcnt));
      hs = mv && bus.out_ready;
      ld = mq.size() > 0 && (!mv || bus.out_ready);
      pu = bus.in_valid && mq.size() < DEPTH;
      if (hs) mcnt = mcnt + 1'b1;
      if (ld) begin
        mcw = ref_enc(mq.pop_front());
        if (bus.inj_en && bus.inj_pos != 3'd0) mcw[bus.inj_pos - 3'd1] = ~mcw[bus.inj_pos - 3'd1];
        mv = 1'b1;
      end else if (hs) mv = 1'b0;
      if (pu) mq.push_back(bus.in_data);
    end
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end
  initial begin
    logic [3:0] sv [6];
    int n;
    bus.in_data = '0;
    bus.in_valid = 1'b0;
    bus.inj_en = 1'b0;
    bus.inj_pos = '0;
    bus.out_ready = 1'b0;
    vt[0]  = '{4'b1011, 1'b0, 3'd0, 7'b1010101};
    vt[1]  = '{4'b0000, 1'b0, 3'd0, 7'b0000000};
    vt[2]  = '{4'b1111, 1'b0, 3'd0, 7'b1111111};
    vt[3]  = '{4'b0001, 1'b0, 3'd0, 7'b0000111};
    vt[4]  = '{4'b0010, 1'b0, 3'd0, 7'b0011001};
    vt[5]  = '{4'b0100, 1'b0, 3'd0, 7'b0101010};
    vt[6]  = '{4'b1000, 1'b0, 3'd0, 7'b1001011};
    vt[7]  = '{4'b1011, 1'b1, 3'd3, 7'b1010001};
    vt[8]  = '{4'b1011, 1'b1, 3'd0, 7'b1010101};
    vt[9]  = '{4'b0000, 1'b1, 3'd7, 7'b1000000};
    vt[10] = '{4'b1111, 1'b0, 3'd5, 7'b1111111};
    #2;
    chk("rst_in_ready", 32'(bus.in_ready), 1);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_out_cw", 32'(bus.out_cw), 0);
    chk("rst_cw_count", 32'(cw_count), 0);
    chk("rst_fifo_lvl", 32'(fifo_lvl), 0);
    tick;
    rst_n = 1'b1;
    tick;
    for (int d = 0; d < 16; d++) begin
      chk("pkg_enc", 32'(hamming74_enc(4'(d))), 32'(ref_enc(4'(d))));
      for (int k = 1; k < 8; k++)
        chk("pkg_syn", 32'(hamming74_syn(hamming74_enc(4'(d)) ^ (7'd1 << (k - 1)))), k);
    end
    for (int i = 0; i < NV; i++) begin
      bus.out_ready = 1'b1;
      bus.in_data = vt[i].d;
      bus.in_valid = 1'b1;
      bus.inj_en = vt[i].en;
      bus.inj_pos = vt[i].pos;
      tick;
      bus.in_valid = 1'b0;
      chk("lat_pre", 32'(bus.out_valid), 0);
      tick;
      chk("lat_post", 32'(bus.out_valid), 1);
      chk($sformatf("vec%0d", i), 32'(bus.out_cw), 32'(vt[i].cw));
      bus.inj_en = 1'b0;
      bus.inj_pos = '0;
      tick;
    end
    chk("cnt_after_table", 32'(cw_count), NV);
    for (int d = 0; d < 16; d++) begin
      bus.in_data = 4'(d);
      bus.in_valid = 1'b1;
      tick;
    end
    bus.in_valid = 1'b0;
    repeat (4) tick;
    sv = '{4'h3, 4'h9, 4'hC, 4'h5, 4'h6, 4'hA};
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.in_data = sv[i];
      bus.in_valid = 1'b1;
      tick;
    end
    chk("stall_lvl", 32'(fifo_lvl), 4);
    chk("stall_in_ready", 32'(bus.in_ready), 0);
    chk("stall_out_valid", 32'(bus.out_valid), 1);
    chk("stall_cw", 32'(bus.out_cw), 32'(ref_enc(sv[0])));
    bus.in_data = sv[5];
    bus.inj_en = 1'b1;
    bus.inj_pos = 3'd1;
    repeat (3) tick;
    chk("stall_6th_blocked", 32'(fifo_lvl), 4);
    chk("stall_inj_ignored", 32'(bus.out_cw), 32'(ref_enc(sv[0])));
    bus.inj_en = 1'b0;
    bus.inj_pos = '0;
    bus.out_ready = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 20) begin
      tick;
      n++;
    end
    chk("stall_release", 32'(bus.in_ready), 1);
    tick;
    bus.in_valid = 1'b0;
    repeat (8) tick;
    chk("stall_drained", 32'(fifo_lvl), 0);
    for (int c = 0; c < 400; c++) begin
      if (!bus.in_valid || bus.in_ready) begin
        bus.in_valid = 1'($urandom_range(0, 1));
        bus.in_data = 4'($urandom);
      end
      bus.out_ready = $urandom_range(0, 3) != 0;
      bus.inj_en = $urandom_range(0, 3) == 0;
      bus.inj_pos = 3'($urandom);
      tick;
    end
    bus.in_valid = 1'b0;
    bus.inj_en = 1'b0;
    bus.out_ready = 1'b1;
    repeat (8) tick;
    bus.out_ready = 1'b0;
    for (int i = 1; i < 4; i++) begin
      bus.in_data = 4'(i);
      bus.in_valid = 1'b1;
      tick;
    end
    bus.in_valid = 1'b0;
    chk("pre_rst_out_valid", 32'(bus.out_valid), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(bus.out_valid), 0);
    chk("mid_rst_fifo_lvl", 32'(fifo_lvl), 0);
    chk("mid_rst_in_ready", 32'(bus.in_ready), 1);
    chk("mid_rst_cw_count", 32'(cw_count), 0);
    tick;
    tick;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    repeat (5) tick;
    chk("post_rst_quiet", 32'(bus.out_valid), 0);
    bus.in_data = 4'h7;
    bus.in_valid = 1'b1;
    tick;
    bus.in_valid = 1'b0;
    tick;
    chk("post_rst_word", 32'(bus.out_cw), 32'(ref_enc(4'h7)));
    repeat (3) tick;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    tick;
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    for (int i = 0; i < (1 << CNT_W) + 5; i++) begin
      bus.in_data = 4'($urandom);
      tick;
    end
    bus.in_valid = 1'b0;
    repeat (4) tick;
    chk("cw_wrap", 32'(cw_count), 5);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
